uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-byte FIFO drained to a UART over UIBI (CTRL enable once, then STATUS poll + TXDATA write per byte).
// Bus outputs are registered and held until bus_ready; in_ready = ~full after the CTRL write. UART_FEEDER_CRLF_EN expands LF to CR LF.
module uart_tx_feeder #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] UART_BASE = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   bus_req,
  output logic                   bus_wen,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_dat_o,
  input  logic [31:0]            bus_dat_i,
  input  logic                   bus_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [31:0] CTRL_ADDR   = UART_BASE + 32'h00;
  localparam logic [31:0] STATUS_ADDR = UART_BASE + 32'h04;
  localparam logic [31:0] TXDATA_ADDR = UART_BASE + 32'h0C;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_feeder: DEPTH must be a power of two in 2..256");
  end

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    WRITE
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        bus_req_q, bus_req_d;
  logic        bus_wen_q, bus_wen_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_dat_q, bus_dat_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       xfer_done;
  logic       uart_busy;
  logic [7:0] head_byte;
  logic [7:0] tx_byte;
  logic       wr_pops;

  // Only bit0 of STATUS carries meaning for this block.
  logic       unused_status_bits;
  assign unused_status_bits = ^bus_dat_i[31:1];
  assign uart_busy          = bus_dat_i[0];

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = (state_q != INIT) && !full;
  assign push      = in_valid && in_ready;
  assign xfer_done = bus_req_q && bus_ready;
  assign head_byte = mem_q[rd_ptr_q];

`ifdef UART_FEEDER_CRLF_EN
  logic cr_sent_q, cr_sent_d;
  logic lf_head;

  assign lf_head = (head_byte == 8'h0A);
  assign tx_byte = (lf_head && !cr_sent_q) ? 8'h0D : head_byte;
  // An LF head stays queued until its CR has gone out; the second pass sends the LF and pops.
  assign wr_pops = !lf_head || cr_sent_q;

  always_comb begin
    cr_sent_d = cr_sent_q;
    if (state_q == WRITE && xfer_done) begin
      cr_sent_d = !wr_pops;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`else
  assign tx_byte = head_byte;
  assign wr_pops = 1'b1;
`endif

  // FSM and bus request generation; a request is raised one cycle after entering a request state.
  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_wen_d  = bus_wen_q;
    bus_addr_d = bus_addr_q;
    bus_dat_d  = bus_dat_q;
    pop        = 1'b0;

    if (xfer_done) begin
      bus_req_d  = 1'b0;
      bus_wen_d  = 1'b0;
      bus_addr_d = '0;
      bus_dat_d  = '0;
    end

    case (state_q)
      INIT: begin
        if (xfer_done) begin
          state_d = IDLE;
        end else if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_wen_d  = 1'b1;
          bus_addr_d = CTRL_ADDR;
          bus_dat_d  = 32'h1;
        end
      end
      IDLE: begin
        if (!empty) begin
          state_d = POLL_REQ;
        end
      end
      POLL_REQ: begin
        if (xfer_done) begin
          state_d = POLL_WAIT;
        end else if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_wen_d  = 1'b0;
          bus_addr_d = STATUS_ADDR;
          bus_dat_d  = '0;
        end
      end
      POLL_WAIT: begin
        state_d = uart_busy ? POLL_REQ : WRITE;
      end
      WRITE: begin
        if (xfer_done) begin
          pop     = wr_pops;
          state_d = IDLE;
        end else if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_wen_d  = 1'b1;
          bus_addr_d = TXDATA_ADDR;
          bus_dat_d  = {24'h0, tx_byte};
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bus_req_q  <= 1'b0;
      bus_wen_q  <= 1'b0;
      bus_addr_q <= '0;
      bus_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bus_req_q  <= bus_req_d;
      bus_wen_q  <= bus_wen_d;
      bus_addr_q <= bus_addr_d;
      bus_dat_q  <= bus_dat_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign count     = count_q;
  assign busy      = !empty || (state_q != IDLE);
  assign bus_req   = bus_req_q;
  assign bus_wen   = bus_wen_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dat_o = bus_dat_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: UIBI slave with scripted/random STATUS and ready, byte-stream scoreboard.
module tb_uart_tx_feeder;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h4000_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_TX   = BASE + 32'h0C;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_data   = 8'h0;
  logic        in_ready;
  logic [4:0]  count;
  logic        busy;
  logic        bus_req;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i = 32'h0;
  logic        bus_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // 0 stall, 1 always ready, 2 random ready, 3 ready except TXDATA writes
  int rdy_mode       = 0;
  int stat_busy_left = 0;
  bit stat_rand      = 1'b0;
  int n_ctrl = 0;
  int n_stat = 0;
  int n_tx   = 0;
  bit ctrl_pending = 1'b1;
  logic [7:0] exp_q[$];

  uart_tx_feeder #(.DEPTH(DEPTH), .UART_BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .count     (count),
    .busy      (busy),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_dat_o (bus_dat_o),
    .bus_dat_i (bus_dat_i),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected UART byte stream for one accepted input byte.
  task automatic model_push(input logic [7:0] b);
`ifdef UART_FEEDER_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 32'(in_ready), 32'd1);
    if (in_ready) model_push(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // UIBI slave: completes on bus_req && bus_ready, returns STATUS one cycle after the read completes.
  initial begin : slave_proc
    bit          prev_hold;
    bit          prev_done;
    bit          rd_done;
    logic        prev_wen;
    logic [31:0] prev_addr;
    logic [31:0] prev_dat;
    logic [31:0] rd_val;
    prev_hold = 1'b0; prev_done = 1'b0; rd_done = 1'b0;
    prev_wen = 1'b0; prev_addr = '0; prev_dat = '0; rd_val = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold    = 1'b0;
        prev_done    = 1'b0;
        rd_done      = 1'b0;
        ctrl_pending = 1'b1;
      end else begin
        if (prev_done) chk("req_gap", 32'(bus_req), 32'd0);
        if (prev_hold) begin
          chk("hold_req", 32'(bus_req), 32'd1);
          chk("hold_wen", 32'(bus_wen), 32'(prev_wen));
          chk("hold_addr", bus_addr, prev_addr);
          chk("hold_dat", bus_dat_o, prev_dat);
        end
        if (bus_req && !bus_wen) begin
          chk("rd_addr", bus_addr, A_STAT);
          chk("rd_dat_o", bus_dat_o, 32'h0);
        end
        prev_done = bus_req && bus_ready;
        prev_hold = bus_req && !bus_ready;
        prev_wen  = bus_wen;
        prev_addr = bus_addr;
        prev_dat  = bus_dat_o;
        rd_done   = 1'b0;
        if (prev_done) begin
          if (ctrl_pending) begin
            chk("first_xfer_wen", 32'(bus_wen), 32'd1);
            chk("first_xfer_addr", bus_addr, A_CTRL);
            chk("first_xfer_dat", bus_dat_o, 32'h1);
            ctrl_pending = 1'b0;
            n_ctrl++;
          end else if (!bus_wen) begin
            n_stat++;
            rd_done = 1'b1;
            rd_val  = $urandom;
            if (stat_busy_left > 0) begin
              rd_val[0] = 1'b1;
              stat_busy_left--;
            end else if (stat_rand) begin
              rd_val[0] = ($urandom_range(3) == 0);
            end else begin
              rd_val[0] = 1'b0;
            end
          end else begin
            chk("wr_addr", bus_addr, A_TX);
            chk("tx_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("tx_byte", bus_dat_o, {24'h0, exp_q.pop_front()});
            n_tx++;
          end
        end
      end
      @(posedge clk); #1;
      bus_dat_i = rd_done ? rd_val : $urandom;
      case (rdy_mode)
        0:       bus_ready = 1'b0;
        1:       bus_ready = 1'b1;
        2:       bus_ready = ($urandom_range(2) != 0);
        default: bus_ready = !(bus_req && bus_wen && bus_addr == A_TX);
      endcase
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main_proc
    int n;
    int s_stat;
    int s_tx;
    int s_ctrl;
    logic [7:0] b;

    // Reset state
    rst      = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wen", 32'(bus_wen), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_dat_o", bus_dat_o, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // CTRL enable after reset, in_ready the cycle after
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t028_in_rdy_init", 32'(in_ready), 32'd0);
    n = 0;
    while (!(bus_req && bus_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t028_ctrl_seen", 32'(bus_req && bus_ready), 32'd1);
    chk("t028_ctrl_addr", bus_addr, A_CTRL);
    chk("t028_ctrl_dat", bus_dat_o, 32'h1);
    chk("t028_in_rdy_during", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t028_in_rdy_after", 32'(in_ready), 32'd1);

    // Single byte, UART idle
    s_stat = n_stat; s_tx = n_tx;
    push(8'h41);
    wait_idle("t029");
    chk("t029_stat_reads", 32'(n_stat - s_stat), 32'd1);
    chk("t029_tx_writes", 32'(n_tx - s_tx), 32'd1);

    // UART busy for three polls
    s_stat = n_stat; s_tx = n_tx;
    stat_busy_left = 3;
    push(8'h55);
    wait_idle("t030");
    chk("t030_stat_reads", 32'(n_stat - s_stat), 32'd4);
    chk("t030_tx_writes", 32'(n_tx - s_tx), 32'd1);

    // Fill with bus stalled, refuse the extra byte, then drain in order
    rdy_mode = 0;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    @(negedge clk);
    chk("t031_full_in_rdy", 32'(in_ready), 32'd0);
    chk("t031_full_count", 32'(count), 32'(DEPTH));
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    chk("t031_refuse_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t031_count_hold", 32'(count), 32'(DEPTH));
    s_tx = n_tx;
    rdy_mode = 1;
    wait_idle("t031");
    chk("t031_tx_writes", 32'(n_tx - s_tx), 32'(DEPTH));

    // Reset while a TXDATA write is stalled
    rdy_mode = 3;
    push(8'h11);
    push(8'h22);
    n = 0;
    @(negedge clk);
    while (!(bus_req && bus_wen && bus_addr == A_TX) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t032_tx_stalled", 32'(bus_req && bus_wen && bus_addr == A_TX), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t032_bus_req", 32'(bus_req), 32'd0);
    chk("t032_count", 32'(count), 32'd0);
    chk("t032_in_ready", 32'(in_ready), 32'd0);
    chk("t032_busy", 32'(busy), 32'd1);
    rdy_mode = 1;
    s_ctrl = n_ctrl;
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    while (n_ctrl == s_ctrl && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t032_reinit", 32'(n_ctrl - s_ctrl), 32'd1);
    push(8'h33);
    wait_idle("t032_recover");

    // LF handling
    s_tx = n_tx;
    push(8'h0A);
    wait_idle("t033");
`ifdef UART_FEEDER_CRLF_EN
    chk("t033_tx_writes", 32'(n_tx - s_tx), 32'd2);
`else
    chk("t033_tx_writes", 32'(n_tx - s_tx), 32'd1);
`endif

    // Random traffic: random ready, random UART busy, LF-heavy data
    rdy_mode  = 2;
    stat_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      b = ($urandom_range(3) == 0) ? 8'h0A : 8'($urandom);
      push(b);
      @(negedge clk);
      chk("rand_busy", 32'(busy), 32'd1);
      repeat ($urandom_range(3)) @(posedge clk);
    end
    wait_idle("rand");
    stat_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
